load_store_unit: RTL and testbench

//  Initiator side of the data_memory interface. Accepts one load/store request at a time from the core.

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, access sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Access size from funct3. Bit 2 only selects signedness, so it is
    // dropped here; any unlisted code falls through to a word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case ({1'b0, f3[1:0]})
            F3_B:    return SZ_B;
            F3_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
        return ((sz == SZ_H) && lane[0]) || ((sz == SZ_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: merges store data into a word and extracts/extends load data.
// Latency: combinational.
// Backpressure: none.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  size_t       st_size,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = word[{lane[1], 4'b0000} +: 16];

    // Store merge: replace only the addressed lane(s); a half always uses lane addr[1].
    always_comb begin
        merged = word;
        case (st_size)
            SZ_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // Load extract: pick the lane, then sign- or zero-extend by funct3.
    always_comb begin
        rdata = word;
        case (funct3)
            F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
            F3_H:    rdata = {{16{half_v[15]}}, half_v};
            F3_BU:   rdata = {24'h0, byte_v};
            F3_HU:   rdata = {16'h0, half_v};
            F3_W:    rdata = word;
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator for data_memory; sub-word stores via read-modify-write.
// Latency: load/SW respond 2 cycles after accept, SB/SH 3; misaligned trap 1 (MISALIGN_TRAP_EN).
// Backpressure: req_ready low while busy; responses cannot be stalled (one-cycle pulse).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    output logic [N-1:0] mem_A,
    output logic [31:0]  mem_WD,
    output logic         mem_WE,
    input  logic [31:0]  mem_RD
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [N-1:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        mem_we_q, mem_we_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    size_t       sz_req, sz_q;
    logic [31:0] merged_word, load_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:N];
    assign sz_req         = f3_size(req_funct3);
    assign sz_q           = f3_size(f3_q);

`ifdef MISALIGN_TRAP_EN
    logic mis_req;
    logic resp_err_q, resp_err_d;
    assign mis_req  = is_misaligned(sz_req, req_addr[1:0]);
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    lsu_align u_align (
        .word    (mem_RD),
        .wdata   (wdata_q),
        .st_size (sz_q),
        .lane    (lane_q),
        .funct3  (f3_q),
        .merged  (merged_word),
        .rdata   (load_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_A      = mem_a_q;
    assign mem_WD     = mem_wd_q;
    assign mem_WE     = mem_we_q;

    // Next-state and next-output decode; all outputs are registered from these.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
`ifdef MISALIGN_TRAP_EN
        resp_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
`ifdef MISALIGN_TRAP_EN
                    // Trapped accesses never touch the memory port.
                    if (mis_req) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    begin
                        mem_a_d = {req_addr[N-1:2], 2'b00};
                        if (req_we && (sz_req == SZ_W)) begin
                            state_d  = ST_WRITE;
                            mem_wd_d = req_wdata;
                            mem_we_d = 1'b1;
                        end else begin
                            state_d  = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d  = ST_WRITE;
                    mem_wd_d = merged_word;
                    mem_we_d = 1'b1;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset clears mem_WE immediately, aborting any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_a_q      <= '0;
            mem_wd_q     <= 32'h0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a byte-array memory and a byte-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_A;
    logic [31:0] mem_WD, mem_RD;
    logic        mem_WE;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    bit          mem_inited = 1'b0;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16:      return 8'hBB;
            17:      return 8'hAA;
            18:      return 8'h99;
            19:      return 8'h88;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    assign mem_RD = {mem[{mem_A[7:2], 2'd3}], mem[{mem_A[7:2], 2'd2}],
                     mem[{mem_A[7:2], 2'd1}], mem[{mem_A[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_inited <= 1'b1;
        end else if (mem_WE) begin
            for (int k = 0; k < 4; k++) mem[{mem_A[7:2], k[1:0]}] <= mem_WD[8*k +: 8];
        end
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}], mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}], ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request through the DUT, checked against the byte-level model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata_o);
        int nbytes, off, base, lat_exp, lat, we_cnt, we_cyc, w;
        bit sgn, mis, trap, got;
        logic [31:0] val_exp;
        logic [7:0]  a_prev, a_c1, aligned;
        logic        err_o;

        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);

        sgn = 1'b0;
        if (we) begin
            case (f3[1:0])
                2'b00:   nbytes = 1;
                2'b01:   nbytes = 2;
                default: nbytes = 4;
            endcase
        end else begin
            case (f3)
                3'b000:  begin nbytes = 1; sgn = 1'b1; end
                3'b001:  begin nbytes = 2; sgn = 1'b1; end
                3'b100:  nbytes = 1;
                3'b101:  nbytes = 2;
                default: nbytes = 4;
            endcase
        end
        mis = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        aligned = addr & 8'hFC;
        off  = (nbytes == 1) ? int'(addr[1:0]) : (nbytes == 2) ? 2 * int'(addr[1]) : 0;
        base = int'(aligned) + off;
        val_exp = 32'h0;
        if (!trap && !we) begin
            for (int k = 0; k < nbytes; k++) val_exp[8*k +: 8] = ref_mem[base + k];
            if (sgn && val_exp[8*nbytes-1])
                for (int k = nbytes; k < 4; k++) val_exp[8*k +: 8] = 8'hFF;
        end
        if (!trap && we)
            for (int k = 0; k < nbytes; k++) ref_mem[base + k] = wd[8*k +: 8];
        lat_exp = trap ? 1 : (!we ? 2 : (nbytes == 4 ? 2 : 3));

        a_prev     = mem_A;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = {$urandom_range(0, 255) & 32'hFFFF_FF00} | {24'h0, addr};
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        got = 1'b0; lat = 0; we_cnt = 0; we_cyc = 0; a_c1 = 8'h0;
        rdata_o = 32'h0; err_o = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1) a_c1 = mem_A;
            if (mem_WE) begin
                we_cnt++;
                we_cyc = c;
            end
            if (resp_valid) begin
                got     = 1'b1;
                lat     = c;
                rdata_o = resp_rdata;
                err_o   = resp_err;
            end
        end
        check("resp_latency", 32'(lat), 32'(lat_exp));
        check("resp_rdata", rdata_o, val_exp);
        check("resp_err", 32'(err_o), 32'(trap));
        check("we_pulses", 32'(we_cnt), (trap || !we) ? 32'd0 : 32'd1);
        check("we_cycle", 32'(we_cyc), (trap || !we) ? 32'd0 : 32'(lat_exp - 1));
        check("mem_A_cycle1", 32'(a_c1), trap ? 32'(a_prev) : 32'(aligned));
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        if (we) check("mem_word_after_store", mem_word(aligned), ref_word(aligned));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] word_before;
        int acc, rsp;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_A", 32'(mem_A), 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        check("rst_mem_WE", 32'(mem_WE), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed loads and stores on the preloaded word 0x8899AABB.
        do_req(1'b0, 3'b000, 8'h11, 32'h0, rd);
        check("lb_0x11", rd, 32'hFFFF_FFAA);
        do_req(1'b0, 3'b100, 8'h11, 32'h0, rd);
        check("lbu_0x11", rd, 32'h0000_00AA);
        do_req(1'b0, 3'b001, 8'h12, 32'h0, rd);
        check("lh_0x12", rd, 32'hFFFF_8899);
        do_req(1'b0, 3'b101, 8'h12, 32'h0, rd);
        check("lhu_0x12", rd, 32'h0000_8899);
        do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);
        check("lw_0x10", rd, 32'h8899_AABB);
        do_req(1'b1, 3'b000, 8'h13, 32'h1234_5677, rd);
        check("sb_0x13_word", mem_word(8'h10), 32'h7799_AABB);
        do_req(1'b1, 3'b001, 8'h10, 32'h0000_CAFE, rd);
        check("sh_0x10_word", mem_word(8'h10), 32'h7799_CAFE);
        do_req(1'b1, 3'b010, 8'h20, 32'hDEAD_BEEF, rd);
        do_req(1'b0, 3'b010, 8'h20, 32'h0, rd);
        check("lw_0x20", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 8'h11, 32'h0, rd);
        do_req(1'b1, 3'b101, 8'h21, 32'h0000_5A5A, rd);

        // req_valid held high: a load accepted every third cycle.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h0;
        acc = 0; rsp = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                check("b2b_rdata", resp_rdata, ref_word(8'h20));
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd4);
        check("b2b_resps", 32'(rsp), 32'd4);
        @(negedge clk);

        // Randomized mix of loads and stores.
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   8'(8'h40 + $urandom_range(0, 63)), $urandom, rd);
        end

        // Reset during the WRITE cycle of SB 0x10 aborts the store.
        word_before = ref_word(8'h10);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h0000_0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_we_before_rst", 32'(mem_WE), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_dropped", 32'(mem_WE), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_word_unchanged", mem_word(8'h10), word_before);
        @(negedge clk);
        do_req(1'b0, 3'b010, 8'h10, 32'h0, rd);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
